// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset control unit: IDLE/DECODE/EXEC/MEM/WB plus HALT and TRAP.
// Define CU_TRAP_EN to enable illegal-instruction and memory-timeout traps.
module multicycle_ctrl #(
    parameter int NR_REGS = 16,
    parameter int TMO_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ack,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  fun3,
    output logic [3:0]  aluc,
    output logic        m1,
    output logic        m2,
    output logic        m3,
    output logic        m5,
    output logic [1:0]  m4,
    output logic        wen_r,
    output logic        pc_we,
    output logic        halt,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    logic [2:0]  state, state_nx;
    logic [31:0] ir;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic is_add, is_sub, is_addi, is_lw, is_sw, is_auipc, is_jal, is_jalr, is_ebreak;
    logic use_rd, use_rs1, use_rs2, reg_bad, legal, writes_rd, in_ex;

    assign opc = ir[6:0];
    assign f3  = ir[14:12];
    assign f7  = ir[31:25];

    assign is_add    = (opc == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0000000);
    assign is_sub    = (opc == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0100000);
    assign is_addi   = (opc == 7'b0010011) && (f3 == 3'b000);
    assign is_lw     = (opc == 7'b0000011) && (f3 == 3'b010);
    assign is_sw     = (opc == 7'b0100011) && (f3 == 3'b010);
    assign is_auipc  = (opc == 7'b0010111);
    assign is_jal    = (opc == 7'b1101111);
    assign is_jalr   = (opc == 7'b1100111) && (f3 == 3'b000);
    assign is_ebreak = (ir == 32'h0010_0073);

    assign use_rd  = is_add | is_sub | is_addi | is_lw | is_auipc | is_jal | is_jalr;
    assign use_rs1 = is_add | is_sub | is_addi | is_lw | is_sw | is_jalr;
    assign use_rs2 = is_add | is_sub | is_sw;

    // RV32E only has x0..x15, so any referenced register index with bit 4 set is illegal.
    assign reg_bad = (NR_REGS == 16) &&
                     ((use_rd && ir[11]) || (use_rs1 && ir[19]) || (use_rs2 && ir[24]));
    assign legal     = (use_rd | use_rs1 | use_rs2) && !reg_bad;
    assign writes_rd = legal && use_rd;

`ifdef CU_TRAP_EN
    // Last count value before the limit; a missing ack in that cycle trips the timeout.
    localparam logic [TMO_W-1:0] TMO_LIM = {{(TMO_W-1){1'b1}}, 1'b0};
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    assign tmo_hit = (tmo_cnt == TMO_LIM);
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (inst_valid) state_nx = S_DECODE;
            S_DECODE: begin
                if (is_ebreak)  state_nx = S_HALT;
`ifdef CU_TRAP_EN
                else if (!legal) state_nx = S_TRAP;
`else
                else if (!legal) state_nx = S_WB;
`endif
                else            state_nx = S_EXEC;
            end
            S_EXEC:   state_nx = (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ack)      state_nx = S_WB;
`ifdef CU_TRAP_EN
                else if (tmo_hit) state_nx = S_TRAP;
`endif
            end
            S_WB:     state_nx = S_IDLE;
            S_HALT:   state_nx = S_HALT;
            S_TRAP:   state_nx = S_TRAP;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && inst_valid) ir <= inst;
        end
    end

`ifdef CU_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt    <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'd0;
        end else begin
            if (state != S_MEM)  tmo_cnt <= '0;
            else if (!mem_ack)   tmo_cnt <= tmo_cnt + 1'b1;
            if (state_nx == S_TRAP && state != S_TRAP) begin
                trap       <= 1'b1;
                trap_cause <= (state == S_MEM) ? 2'd2 : 2'd1;
            end
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TMO_W > 0);
    assign trap       = 1'b0;
    assign trap_cause = 2'd0;
`endif

    // Selects derive from the held instruction, so they stay constant from EXEC through WB.
    assign in_ex = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

    always_comb begin
        aluc = 4'd0;
        m1   = 1'b0;
        m2   = 1'b0;
        m3   = 1'b0;
        m4   = 2'd0;
        m5   = 1'b0;
        if (in_ex && legal) begin
            aluc = is_sub ? 4'd1 : (is_jalr ? 4'd2 : 4'd0);
            m1   = is_auipc | is_jal;
            m2   = is_addi | is_jalr | is_lw | is_sw;
            m3   = is_jal | is_jalr;
            m4   = is_lw ? 2'd1 : ((is_jal | is_jalr) ? 2'd2 : 2'd0);
            m5   = is_lw;
        end
    end

    assign inst_ready = (state == S_IDLE);
    assign mem_req    = (state == S_MEM);
    assign mem_we     = (state == S_MEM) && is_sw;
    assign mem_wmask  = ((state == S_MEM) && is_sw) ? 8'h0F : 8'h00;
    assign pc_we      = (state == S_WB);
    assign wen_r      = (state == S_WB) && writes_rd && (ir[11:7] != 5'd0);
    assign halt       = (state == S_HALT);

    assign rd   = ir[11:7];
    assign rs1  = ir[19:15];
    assign rs2  = ir[24:20];
    assign fun3 = ir[14:12];

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: an RV32E instance (a) and an RV32I instance (b), TMO_W=4.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] inst = '0;
    logic mem_ack = 1'b0;
    logic a_valid = 1'b0, b_valid = 1'b0;

    logic a_inst_ready, a_mem_req, a_mem_we, a_m1, a_m2, a_m3, a_m5, a_wen_r, a_pc_we, a_halt, a_trap;
    logic [7:0] a_mem_wmask;
    logic [4:0] a_rd, a_rs1, a_rs2;
    logic [2:0] a_fun3;
    logic [3:0] a_aluc;
    logic [1:0] a_m4, a_trap_cause;

    logic b_inst_ready, b_mem_req, b_mem_we, b_m1, b_m2, b_m3, b_m5, b_wen_r, b_pc_we, b_halt, b_trap;
    logic [7:0] b_mem_wmask;
    logic [4:0] b_rd, b_rs1, b_rs2;
    logic [2:0] b_fun3;
    logic [3:0] b_aluc;
    logic [1:0] b_m4, b_trap_cause;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.NR_REGS(16), .TMO_W(4)) dut_a (
        .clk(clk), .rst(rst), .inst_valid(a_valid), .inst_ready(a_inst_ready), .inst(inst),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_wmask(a_mem_wmask), .mem_ack(mem_ack),
        .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2), .fun3(a_fun3), .aluc(a_aluc),
        .m1(a_m1), .m2(a_m2), .m3(a_m3), .m5(a_m5), .m4(a_m4),
        .wen_r(a_wen_r), .pc_we(a_pc_we), .halt(a_halt), .trap(a_trap), .trap_cause(a_trap_cause)
    );

    multicycle_ctrl #(.NR_REGS(32), .TMO_W(4)) dut_b (
        .clk(clk), .rst(rst), .inst_valid(b_valid), .inst_ready(b_inst_ready), .inst(inst),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_wmask(b_mem_wmask), .mem_ack(mem_ack),
        .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .fun3(b_fun3), .aluc(b_aluc),
        .m1(b_m1), .m2(b_m2), .m3(b_m3), .m5(b_m5), .m4(b_m4),
        .wen_r(b_wen_r), .pc_we(b_pc_we), .halt(b_halt), .trap(b_trap), .trap_cause(b_trap_cause)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; mem_ack = 1'b0; inst = '0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        total++; if (a_inst_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0d exp=1", a_inst_ready); end
        total++; if ({a_mem_req, a_mem_we, a_mem_wmask} !== 10'h0) begin bad++; $display("FAIL rst_mem got=%0h exp=0", {a_mem_req, a_mem_we, a_mem_wmask}); end
        total++; if ({a_wen_r, a_pc_we, a_halt, a_trap, a_trap_cause} !== 6'h0) begin bad++; $display("FAIL rst_ctl got=%0h exp=0", {a_wen_r, a_pc_we, a_halt, a_trap, a_trap_cause}); end
        total++; if ({a_rd, a_rs1, a_rs2, a_fun3} !== 18'h0) begin bad++; $display("FAIL rst_fields got=%0h exp=0", {a_rd, a_rs1, a_rs2, a_fun3}); end
        total++; if ({a_aluc, a_m1, a_m2, a_m3, a_m4, a_m5} !== 10'h0) begin bad++; $display("FAIL rst_mux got=%0h exp=0", {a_aluc, a_m1, a_m2, a_m3, a_m4, a_m5}); end
    endtask

    task automatic test_addi;
        do_reset;
        inst = 32'h0050_0093; a_valid = 1'b1;
        tick; a_valid = 1'b0;                       // cycle 1: DECODE
        total++; if (a_inst_ready !== 1'b0) begin bad++; $display("FAIL addi_busy got=%0d exp=0", a_inst_ready); end
        tick;                                       // cycle 2: EXEC
        total++; if ({a_aluc, a_m2, a_m1} !== 6'b0000_10) begin bad++; $display("FAIL addi_exec_sel got=%0b exp=000010", {a_aluc, a_m2, a_m1}); end
        total++; if (a_rd !== 5'd1 || a_pc_we !== 1'b0) begin bad++; $display("FAIL addi_exec rd=%0d pc_we=%0d exp rd=1 pc_we=0", a_rd, a_pc_we); end
        tick;                                       // cycle 3: WB
        total++; if ({a_wen_r, a_pc_we} !== 2'b11) begin bad++; $display("FAIL addi_wb got=%0b exp=11", {a_wen_r, a_pc_we}); end
        total++; if (a_m2 !== 1'b1 || a_m4 !== 2'd0) begin bad++; $display("FAIL addi_wb_sel m2=%0d m4=%0d exp m2=1 m4=0", a_m2, a_m4); end
        tick;                                       // cycle 4: IDLE
        total++; if ({a_inst_ready, a_wen_r, a_pc_we} !== 3'b100) begin bad++; $display("FAIL addi_done got=%0b exp=100", {a_inst_ready, a_wen_r, a_pc_we}); end
    endtask

    task automatic test_back_to_back;
        do_reset;
        inst = 32'h0050_0093; a_valid = 1'b1;
        tick;
        inst = 32'h0070_0193;                       // addi x3,x0,7 held valid while busy
        tick; tick;                                 // cycle 3
        total++; if (a_rd !== 5'd1 || a_pc_we !== 1'b1) begin bad++; $display("FAIL b2b_first rd=%0d pc_we=%0d exp rd=1 pc_we=1", a_rd, a_pc_we); end
        tick;                                       // cycle 4: accepts second
        total++; if (a_inst_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0d exp=1", a_inst_ready); end
        tick; a_valid = 1'b0;                       // cycle 5
        total++; if (a_rd !== 5'd3 || a_inst_ready !== 1'b0) begin bad++; $display("FAIL b2b_second rd=%0d ready=%0d exp rd=3 ready=0", a_rd, a_inst_ready); end
        tick; tick;                                 // cycle 7
        total++; if ({a_wen_r, a_pc_we} !== 2'b11) begin bad++; $display("FAIL b2b_second_wb got=%0b exp=11", {a_wen_r, a_pc_we}); end
    endtask

    task automatic test_sw;
        int req_cnt = 0;
        bit wen_seen = 1'b0, pc_seen = 1'b0;
        do_reset;
        inst = 32'h0020_A023; a_valid = 1'b1; mem_ack = 1'b1;   // stray ack before MEM
        tick; a_valid = 1'b0;
        tick;
        total++; if (a_mem_req !== 1'b0) begin bad++; $display("FAIL sw_exec_req got=%0d exp=0", a_mem_req); end
        tick;                                       // cycle 3: MEM
        for (int i = 0; i < 20; i++) begin
            if (a_wen_r) wen_seen = 1'b1;
            if (a_pc_we) begin pc_seen = 1'b1; break; end
            if (a_mem_req) begin
                req_cnt++;
                total++; if ({a_mem_we, a_mem_wmask} !== 9'h10F) begin bad++; $display("FAIL sw_mem_sig got=%0h exp=10f", {a_mem_we, a_mem_wmask}); end
            end
            mem_ack = (req_cnt == 4);
            tick;
        end
        mem_ack = 1'b0;
        total++; if (req_cnt !== 4) begin bad++; $display("FAIL sw_req_cycles got=%0d exp=4", req_cnt); end
        total++; if (pc_seen !== 1'b1 || wen_seen !== 1'b0 || a_wen_r !== 1'b0) begin bad++; $display("FAIL sw_wb pc=%0d wen=%0d exp pc=1 wen=0", pc_seen, wen_seen | a_wen_r); end
    endtask

    task automatic test_illegal;
        do_reset;
        inst = 32'h0020_8833; a_valid = 1'b1; b_valid = 1'b1;   // add x16,x1,x2
        tick; a_valid = 1'b0; b_valid = 1'b0;
        tick;                                       // cycle 2
`ifdef CU_TRAP_EN
        total++; if ({a_trap, a_trap_cause, a_pc_we} !== 4'b1010) begin bad++; $display("FAIL ill_a_trap got=%0b exp=1010", {a_trap, a_trap_cause, a_pc_we}); end
`else
        total++; if ({a_pc_we, a_wen_r} !== 2'b10) begin bad++; $display("FAIL ill_a_nop got=%0b exp=10", {a_pc_we, a_wen_r}); end
`endif
        total++; if (b_pc_we !== 1'b0) begin bad++; $display("FAIL ill_b_exec got=%0d exp=0", b_pc_we); end
        tick;                                       // cycle 3
        total++; if ({b_wen_r, b_pc_we, b_rd} !== 7'b11_10000) begin bad++; $display("FAIL ill_b_wb got=%0b exp=1110000", {b_wen_r, b_pc_we, b_rd}); end
`ifdef CU_TRAP_EN
        total++; if ({a_trap, a_wen_r, a_inst_ready} !== 3'b100) begin bad++; $display("FAIL ill_a_sticky got=%0b exp=100", {a_trap, a_wen_r, a_inst_ready}); end
`else
        total++; if ({a_inst_ready, a_trap} !== 2'b10) begin bad++; $display("FAIL ill_a_idle got=%0b exp=10", {a_inst_ready, a_trap}); end
`endif
        do_reset;
        inst = 32'h0020_9833; b_valid = 1'b1;       // funct3=001 unsupported
        tick; b_valid = 1'b0;
        tick;
`ifdef CU_TRAP_EN
        total++; if ({b_trap, b_trap_cause, b_pc_we} !== 4'b1010) begin bad++; $display("FAIL f3_b_trap got=%0b exp=1010", {b_trap, b_trap_cause, b_pc_we}); end
`else
        total++; if ({b_pc_we, b_wen_r} !== 2'b10) begin bad++; $display("FAIL f3_b_nop got=%0b exp=10", {b_pc_we, b_wen_r}); end
`endif
    endtask

    task automatic test_lw_timeout;
        int cnt = 0;
        bit wen_seen = 1'b0;
        do_reset;
        inst = 32'h0000_A283; a_valid = 1'b1;       // lw x5,0(x1)
        tick; a_valid = 1'b0;
        tick; tick;                                 // cycle 3: MEM
`ifdef CU_TRAP_EN
        for (int i = 0; i < 40; i++) begin
            if (a_trap) break;
            if (a_mem_req) cnt++;
            if (a_wen_r) wen_seen = 1'b1;
            tick;
        end
        total++; if (cnt !== 15) begin bad++; $display("FAIL lw_tmo_cycles got=%0d exp=15", cnt); end
        total++; if ({a_trap, a_trap_cause, a_mem_req, wen_seen} !== 5'b11000) begin bad++; $display("FAIL lw_tmo_trap got=%0b exp=11000", {a_trap, a_trap_cause, a_mem_req, wen_seen}); end
`else
        for (int i = 0; i < 20; i++) begin
            if (a_mem_req) cnt++;
            tick;
        end
        total++; if (cnt !== 20 || a_mem_req !== 1'b1) begin bad++; $display("FAIL lw_wait got=%0d req=%0d exp=20 req=1", cnt, a_mem_req); end
`endif
        do_reset;
        cnt = 0;
        inst = 32'h0000_A283; a_valid = 1'b1;
        tick; a_valid = 1'b0;
        tick; tick;
        total++; if ({a_mem_req, a_mem_we, a_mem_wmask, a_m4, a_m5} !== 13'b1_0_00000000_01_1) begin bad++; $display("FAIL lw_mem_sig got=%0b exp=1000000000011", {a_mem_req, a_mem_we, a_mem_wmask, a_m4, a_m5}); end
        for (int i = 0; i < 40; i++) begin
            if (a_pc_we) break;
            if (a_mem_req) cnt++;
            mem_ack = a_mem_req && (cnt == 15);
            tick;
        end
        mem_ack = 1'b0;
        total++; if (cnt !== 15) begin bad++; $display("FAIL lw_ack_cycles got=%0d exp=15", cnt); end
        total++; if ({a_pc_we, a_wen_r, a_m4, a_m5, a_trap, a_rd} !== 11'b1_1_01_1_0_00101) begin bad++; $display("FAIL lw_ack_wb got=%0b exp=11011000101", {a_pc_we, a_wen_r, a_m4, a_m5, a_trap, a_rd}); end
    endtask

    task automatic test_ebreak;
        bit viol = 1'b0;
        do_reset;
        inst = 32'h0010_0073; a_valid = 1'b1;
        tick; a_valid = 1'b0;
        tick;                                       // cycle 2: HALT
        total++; if ({a_halt, a_trap} !== 2'b10) begin bad++; $display("FAIL ebreak_halt got=%0b exp=10", {a_halt, a_trap}); end
        inst = 32'h0050_0093; a_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (a_pc_we || a_wen_r || a_inst_ready || !a_halt) viol = 1'b1;
            tick;
        end
        a_valid = 1'b0;
        total++; if (viol !== 1'b0) begin bad++; $display("FAIL ebreak_sticky got=%0d exp=0", viol); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++; if ({a_halt, a_inst_ready} !== 2'b01) begin bad++; $display("FAIL ebreak_rst got=%0b exp=01", {a_halt, a_inst_ready}); end
    endtask

    task automatic test_reset_in_mem;
        do_reset;
        inst = 32'h0000_A283; a_valid = 1'b1;
        tick; a_valid = 1'b0;
        tick; tick;
        total++; if (a_mem_req !== 1'b1) begin bad++; $display("FAIL rmem_req got=%0d exp=1", a_mem_req); end
        rst = 1'b1;
        tick;
        total++; if ({a_mem_req, a_inst_ready, a_pc_we, a_wen_r} !== 4'b0100) begin bad++; $display("FAIL rmem_after got=%0b exp=0100", {a_mem_req, a_inst_ready, a_pc_we, a_wen_r}); end
        rst = 1'b0;
        tick;
        total++; if ({a_inst_ready, a_pc_we, a_wen_r} !== 3'b100) begin bad++; $display("FAIL rmem_idle got=%0b exp=100", {a_inst_ready, a_pc_we, a_wen_r}); end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_back_to_back;
        test_sw;
        test_illegal;
        test_lw_timeout;
        test_ebreak;
        test_reset_in_mem;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter NR_REGS, default 16: architectural register count; 16 selects RV32E index checking, 32 disables it.
REQ-002 SHALL have parameter TMO_W, default 8: width of the memory-wait timeout counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  sync active-high reset.
- inst_valid  in  1  instruction offered.
- inst_ready  out  1  controller can accept an instruction.
- inst  in  32  instruction word.
- mem_req  out  1  data-memory request.
- mem_we  out  1  request is a write.
- mem_wmask  out  8  byte write mask.
- mem_ack  in  1  memory done.
- rd, rs1, rs2  out  5 each  latched register fields.
- fun3  out  3  latched inst[14:12].
- aluc  out  4  ALU op: 0 ADD, 1 SUB, 2 ADD_JALR.
- m1, m2, m3, m5  out  1 each  datapath mux selects.
- m4  out  2  writeback mux select.
- wen_r  out  1  register-file write pulse.
- pc_we  out  1  PC update pulse.
- halt  out  1  ebreak reached.
- trap  out  1  fault latched.
- trap_cause  out  2  1 illegal instruction, 2 memory timeout.

Function
REQ-005 SHALL implement FSM states IDLE, DECODE, EXEC, MEM, WB, HALT and TRAP.
REQ-006 IDLE SHALL drive inst_ready=1; on inst_valid&inst_ready it SHALL latch inst and go to DECODE. inst_ready SHALL be 0 in every other state.
REQ-007 DECODE SHALL classify the instruction:
- supported: add, sub (R); addi; lw; sw; auipc; jal; jalr; ebreak.
- ebreak -> HALT; illegal -> TRAP; otherwise -> EXEC.
REQ-008 The instruction SHALL be illegal if its opcode, funct3 or funct7 is unsupported.
REQ-009 With NR_REGS=16, the instruction SHALL also be illegal if any used rd/rs1/rs2 field has bit 4 set.
REQ-010 EXEC SHALL go to MEM for lw/sw and to WB otherwise.
REQ-011 Mux selects and aluc SHALL be valid from EXEC through WB and held constant during that span.
REQ-012 Mux and aluc encodings per class:
- R: m1=src1, m2=src2, m4=result.
- I/L/S: m2=imm.
- auipc, jal: m1=pc.
- jal, jalr: m3=result, m4=PC+4.
- lw: m4=memdat, m5=result.
REQ-013 MEM SHALL hold mem_req=1 until the cycle mem_ack=1. It SHALL drive mem_we=1 and mem_wmask=8'h0F for sw, and mem_we=0 and mem_wmask=8'h00 for lw. On ack it SHALL go to WB.
REQ-014 WB SHALL assert pc_we for exactly one cycle. In the same cycle it SHALL assert wen_r only for register-writing instructions with rd!=0 (add, sub, addi, lw, auipc, jal, jalr). It SHALL then return to IDLE.
REQ-015 Latency:
- non-memory instruction: accept at cycle 0, pc_we at cycle 3, inst_ready again at cycle 4.
- memory instruction: add the cycles spent waiting for mem_ack.
REQ-016 HALT SHALL assert halt=1, issue no further pc_we or wen_r, and is exited only by rst.
REQ-017 inst_valid asserted outside IDLE SHALL be ignored and no instruction SHALL be lost.
REQ-018 mem_ack arriving outside MEM SHALL be ignored.

Reset
REQ-019 When rst=1 at a clock edge, the FSM SHALL go to IDLE and clear the latched instruction, the timeout counter, trap and trap_cause.
REQ-020 Output values after reset: inst_ready=1; all other outputs 0.
REQ-021 A reset during MEM SHALL drop mem_req in the following cycle with no wen_r or pc_we.

Configuration
REQ-022 Macro CU_TRAP_EN SHALL control fault detection.
REQ-023 CU_TRAP_EN defined:
- illegal instruction -> TRAP with trap_cause=1.
- MEM counts cycles without ack; when the count reaches 2^TMO_W-1 -> TRAP with trap_cause=2.
- mem_ack in the same cycle as the limit SHALL win (go to WB, no trap).
- TRAP holds trap=1 until rst.
REQ-024 CU_TRAP_EN undefined:
- no counter and no TRAP state; trap and trap_cause tied to 0.
- illegal instruction executes as a NOP: DECODE -> WB with pc_we only.
- MEM waits for ack indefinitely.

Verification
REQ-025 Bench SHALL cover these directed scenarios:
- addi x1,x0,5 (0x00500093) accepted at cycle 0 -> aluc=0, m2=imm at cycle 2; wen_r=1 and pc_we=1 at cycle 3; inst_ready=1 at cycle 4.
- sw x2,0(x1) with mem_ack held low for 3 cycles -> mem_req high for 4 cycles with mem_we=1, mem_wmask=0x0F; wen_r never asserted.
- add x16,x1,x2 with NR_REGS=16 and CU_TRAP_EN -> trap=1, trap_cause=1, no wen_r; same instruction with NR_REGS=32 -> wen_r pulses.
- lw with no ack, TMO_W=4, CU_TRAP_EN -> trap_cause=2 after 15 MEM cycles; ack given on cycle 15 instead -> WB with wen_r, m4=memdat.
- ebreak (0x00100073) -> halt=1 sticky; further inst_valid ignored; rst -> halt=0, inst_ready=1.
- rst asserted during MEM -> mem_req=0 next cycle, state IDLE, no pc_we.
